pc_ir: RTL

- Program-counter and instruction-register stage of mycpu.
- Sits directly upstream of the control unit `cu`.
  - Consumes the `cu` outputs il_out and ps_out.
  - Drives the `cu` input ins_in from its instruction register.
  - Addresses instruction memory with the PC.
- Inserts fetch stalls when instruction memory is not ready.
- Keeps a count of fetched instructions for debug and performance tracing.

---
 rtl/pc_ir.sv | 69 ++++++
 1 files changed

// File: rtl/pc_ir.sv
`default_nettype none
// ============================================================================
// pc_ir : program counter and instruction register fetch stage for mycpu
// Revision: 1.0
// ============================================================================
module pc_ir #(
  parameter int          PC_W     = 16,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            il_in,
  input  logic [1:0]      ps_in,
  input  logic [15:0]     ra_in,
  input  logic [15:0]     imem_data_in,
  input  logic            imem_rdy_in,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     ins_out,
  output logic            stall_out,
  output logic            ir_valid_out,
  output logic [15:0]     fetch_cnt_out
);

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  logic            upd;
  logic [5:0]      br_off;
  logic [15:0]     br_off_ext;
  logic [PC_W-1:0] pc_next;

  assign stall_out = il_in & ~imem_rdy_in & ~rst;
  assign upd       = ~rst & ~stall_out;

  // Offset is sign-extended to 16 bits first so narrow PC widths just truncate.
  assign br_off     = {ins_out[8:6], ins_out[2:0]};
  assign br_off_ext = {{10{br_off[5]}}, br_off};

  always_comb begin
    pc_next = pc_out;
    case (ps_in)
      PS_HOLD: pc_next = pc_out;
      PS_INC:  pc_next = pc_out + {{(PC_W-1){1'b0}}, 1'b1};
      PS_BR:   pc_next = pc_out + br_off_ext[PC_W-1:0];
      PS_JMP:  pc_next = ra_in[PC_W-1:0];
      default: pc_next = pc_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out        <= RESET_PC[PC_W-1:0];
      ins_out       <= 16'h0000;
      ir_valid_out  <= 1'b0;
      fetch_cnt_out <= 16'h0000;
    end else if (upd) begin
      pc_out <= pc_next;
      if (il_in) begin
        ins_out       <= imem_data_in;
        ir_valid_out  <= 1'b1;
        fetch_cnt_out <= fetch_cnt_out + 16'h0001;
      end
    end
  end

endmodule
`default_nettype wire
